// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder step per clock, IDLE/RUN/DONE control.
// Optional signed-overflow output ovf when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int IW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IW-1:0] idx;
    logic carry, last, bit_a, bit_b, maj;
    assign last  = idx == IW'(WIDTH - 1);
    assign bit_a = a_reg[idx];
    assign bit_b = b_reg[idx];
    assign maj   = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_comb begin
        state_nxt = (state == IDLE && start) ? RUN  :
                    (state == RUN && last)   ? DONE :
                    (state == DONE)          ? IDLE : state;
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum[idx] <= bit_a ^ bit_b ^ carry;
            carry    <= maj;
            // idx parks on the MSB so it never wraps inside an operation
            if (!last) idx <= idx + 1'b1;
            if (last) cout <= maj;
`ifdef SERIAL_ADDER_OVF_EN
            if (last) ovf <= carry ^ maj;
`endif
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=16 and WIDTH=4).
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic reset, start, cin, busy, done, cout;
    logic [15:0] a, b, sum;
    logic start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic ovf, ovf4;
`endif
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch16(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done16(output int nbusy, output bit seen);
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) step();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout); else passed++;
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else passed++;
`endif
        start = 1'b0;
        reset = 1'b0;
        step();
        step();
        total++; if (busy !== 1'b0) $display("FAIL start_during_reset_ignored: busy got %b expected 0", busy); else passed++;
    endtask

    task automatic test_carry_chain();
        int nb;
        bit seen;
        launch16(16'hFFFF, 16'h0001, 1'b0);
        wait_done16(nb, seen);
        total++; if (seen !== 1'b1) $display("FAIL chain_done_seen: got %b expected 1", seen); else passed++;
        total++; if (nb != 16) $display("FAIL chain_busy_cycles: got %0d expected 16", nb); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL chain_busy_with_done: got %b expected 0", busy); else passed++;
        total++; if (sum !== 16'h0000) $display("FAIL chain_sum: got %h expected 0000", sum); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL chain_cout: got %b expected 1", cout); else passed++;
        step();
        total++; if (done !== 1'b0) $display("FAIL chain_done_one_cycle: got %b expected 0", done); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL chain_cout_hold: got %b expected 1", cout); else passed++;
    endtask

    task automatic test_reset_abort();
        int nb, ndone;
        bit seen;
        launch16(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (5) step();
        total++; if (sum !== 16'h001F) $display("FAIL abort_partial_sum: got %h expected 001f", sum); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL abort_prev_cout: got %b expected 1", cout); else passed++;
        #3;
        reset = 1'b1;
        #1;
        total++; if (sum !== 16'h0000) $display("FAIL abort_async_sum: got %h expected 0000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL abort_async_cout: got %b expected 0", cout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_async_busy: got %b expected 0", busy); else passed++;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        total++; if (ndone != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); else passed++;
        launch16(16'd3, 16'd4, 1'b0);
        wait_done16(nb, seen);
        total++; if (seen !== 1'b1) $display("FAIL abort_rerun_done: got %b expected 1", seen); else passed++;
        total++; if (sum !== 16'd7) $display("FAIL abort_rerun_sum: got %h expected 0007", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL abort_rerun_cout: got %b expected 0", cout); else passed++;
        step();
    endtask

    task automatic test_isolation();
        int nb;
        bit seen;
        launch16(16'h1234, 16'h4321, 1'b1);
        a = 16'hAAAA;
        b = 16'hAAAA;
        cin = 1'b0;
        wait_done16(nb, seen);
        total++; if (seen !== 1'b1) $display("FAIL iso_done: got %b expected 1", seen); else passed++;
        total++; if (sum !== 16'h5556) $display("FAIL iso_sum: got %h expected 5556", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL iso_cout: got %b expected 0", cout); else passed++;
        step();
        step();
        total++; if (sum !== 16'h5556) $display("FAIL iso_sum_hold: got %h expected 5556", sum); else passed++;
    endtask

    task automatic test_back_to_back();
        int t[$];
        int nb;
        bit seen;
        int overlap = 0;
        a = 16'h0F0F;
        b = 16'h0101;
        cin = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (busy && done) overlap++;
            if (done) begin
                t.push_back(c);
                total++; if (sum !== 16'h1010) $display("FAIL b2b_sum: got %h expected 1010", sum); else passed++;
            end
            step();
        end
        start = 1'b0;
        total++; if (overlap != 0) $display("FAIL b2b_busy_done_overlap: got %0d expected 0", overlap); else passed++;
        total++; if (t.size() != 3) $display("FAIL b2b_done_count: got %0d expected 3", t.size());
        else begin
            passed++;
            total++; if (t[0] != 17) $display("FAIL b2b_first_latency: got %0d expected 17", t[0]); else passed++;
            total++; if (t[1] - t[0] != 18) $display("FAIL b2b_spacing1: got %0d expected 18", t[1] - t[0]); else passed++;
            total++; if (t[2] - t[1] != 18) $display("FAIL b2b_spacing2: got %0d expected 18", t[2] - t[1]); else passed++;
        end
        wait_done16(nb, seen);
        step();
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int nb;
        bit seen;
        launch16(16'h7FFF, 16'h0001, 1'b0);
        wait_done16(nb, seen);
        total++; if ({cout, ovf, sum} !== {1'b0, 1'b1, 16'h8000}) $display("FAIL ovf_pos: got %b %b %h expected 0 1 8000", cout, ovf, sum); else passed++;
        step();
        launch16(16'h8000, 16'h8000, 1'b0);
        wait_done16(nb, seen);
        total++; if ({cout, ovf, sum} !== {1'b1, 1'b1, 16'h0000}) $display("FAIL ovf_neg: got %b %b %h expected 1 1 0000", cout, ovf, sum); else passed++;
        step();
        launch16(16'h1234, 16'h4321, 1'b1);
        wait_done16(nb, seen);
        total++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h5556}) $display("FAIL ovf_none: got %b %b %h expected 0 0 5556", cout, ovf, sum); else passed++;
        step();
    endtask
`endif

    task automatic test_width4();
        logic [4:0] expv;
        logic [3:0] low;
        bit seen;
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai);
                    b4 = 4'(bi);
                    cin4 = ci[0];
                    start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    seen = 1'b0;
                    for (int k = 0; k < 10 && !seen; k++)
                        if (done4) seen = 1'b1;
                        else step();
                    expv = 5'(ai + bi + ci);
                    total++;
                    if (!seen) $display("FAIL w4_timeout a=%0d b=%0d cin=%0d: done got 0 expected 1", ai, bi, ci);
                    else if ({cout4, sum4} !== expv) $display("FAIL w4_sum a=%0d b=%0d cin=%0d: got %h expected %h", ai, bi, ci, {cout4, sum4}, expv);
                    else passed++;
`ifdef SERIAL_ADDER_OVF_EN
                    low = 4'((ai & 7) + (bi & 7) + ci);
                    total++;
                    if (ovf4 !== (low[3] ^ expv[4])) $display("FAIL w4_ovf a=%0d b=%0d cin=%0d: got %b expected %b", ai, bi, ci, ovf4, low[3] ^ expv[4]);
                    else passed++;
`else
                    low = '0;
`endif
                    step();
                end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_reset_abort();
        test_isolation();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_width4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
